// File: rtl/dut_reset_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dut_reset_pkg
// Purpose  : Shared types and constants for the DUT reset sequencer: FSM
//            state encoding, default pulse length, counter widths and a
//            helper that resolves the effective reset pulse length.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package dut_reset_pkg;

    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_ASSERT  = 3'd2,
        ST_HOLDOFF = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam int unsigned c_default_pulse = 10;
    localparam int unsigned c_cnt_w         = 16;
    localparam int unsigned c_tmr_w         = 8;

    // A requested length of zero falls back to the default pulse.
    function automatic logic [c_tmr_w-1:0] eff_pulse(
        input logic [c_tmr_w-1:0] len,
        input logic [c_tmr_w-1:0] dflt
    );
        return (len == '0) ? dflt : len;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dut_reset_timer.sv
`default_nettype none
// ============================================================================
// Module   : dut_reset_timer
// Purpose  : Loadable down-counter used to time every FSM phase.
// Ports    : clk        - clock
//            rst        - synchronous active-high reset (loads RESET_VAL)
//            load_i     - load load_val_i (wins over en_i)
//            load_val_i - value to load
//            en_i       - decrement by one, holding at zero
//            zero_o     - counter currently equals zero
// Revision : 1.0 - initial release
// ============================================================================
module dut_reset_timer
    import dut_reset_pkg::*;
#(
    parameter int unsigned RESET_VAL = c_default_pulse
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_i,
    input  logic [c_tmr_w-1:0] load_val_i,
    input  logic               en_i,
    output logic               zero_o
);

    logic [c_tmr_w-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= c_tmr_w'(RESET_VAL);
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign zero_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/dut_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : dut_reset_seq
// Purpose  : Generates power-on and on-request reset pulses for NUM_DUTS
//            downstream DUTs, with optional reverse-reset qualifier and a
//            post-deassertion hold-off period. All outputs are registered.
// Ports    : clk, reset            - clock, synchronous active-high reset
//            req/ack               - request handshake (ack = 1-cycle pulse)
//            req_reverse, req_mask - variant and DUT select, sampled on accept
//            pulse_len, holdoff_len- phase lengths, sampled on accept
//            busy, done            - status; done pulses at completion
//            dut_reset             - per-DUT active-high reset
//            dut_reverse_reset     - reverse qualifier, only with a reset
//            reset_count           - completed non-empty sequences (saturating)
// Revision : 1.0 - initial release
// ============================================================================
module dut_reset_seq
    import dut_reset_pkg::*;
#(
    parameter int unsigned NUM_DUTS      = 1,
    parameter int unsigned DEFAULT_PULSE = c_default_pulse
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                req_reverse,
    input  logic [NUM_DUTS-1:0] req_mask,
    input  logic [7:0]          pulse_len,
    input  logic [7:0]          holdoff_len,
    output logic                ack,
    output logic                busy,
    output logic [NUM_DUTS-1:0] dut_reset,
    output logic                dut_reverse_reset,
    output logic                done,
    output logic [c_cnt_w-1:0]  reset_count
);

    localparam logic [c_tmr_w-1:0] c_def_len = c_tmr_w'(DEFAULT_PULSE);

    state_e                state_q, state_d;
    logic [NUM_DUTS-1:0]   mask_q, mask_d;
    logic                  rev_q, rev_d;
    logic [c_tmr_w-1:0]    hold_q, hold_d;
    logic [c_cnt_w-1:0]    cnt_q, cnt_d;
    logic                  ack_q, ack_d;
    logic                  done_q, done_d;
    logic                  busy_q, busy_d;
    logic [NUM_DUTS-1:0]   dut_rst_q, dut_rst_d;
    logic                  dut_rev_q, dut_rev_d;

    logic                  w_tmr_load;
    logic [c_tmr_w-1:0]    w_tmr_val;
    logic                  w_tmr_en;
    logic                  w_tmr_zero;
    logic [c_tmr_w-1:0]    w_pulse;

    dut_reset_timer #(
        .RESET_VAL (DEFAULT_PULSE)
    ) u_timer (
        .clk        (clk),
        .rst        (reset),
        .load_i     (w_tmr_load),
        .load_val_i (w_tmr_val),
        .en_i       (w_tmr_en),
        .zero_o     (w_tmr_zero)
    );

    // Each timed phase loads length-1 and leaves on the cycle the timer
    // reads zero, so a phase of length N spans exactly N cycles.
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        rev_d      = rev_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
        w_tmr_en   = 1'b0;
        w_pulse    = eff_pulse(pulse_len, c_def_len);

        case (state_q)
            ST_INIT: begin
                if (w_tmr_zero) state_d = ST_IDLE;
                else            w_tmr_en = 1'b1;
            end
            ST_IDLE: begin
                if (req) begin
                    mask_d     = req_mask;
                    rev_d      = req_reverse;
                    hold_d     = holdoff_len;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = w_pulse - 1'b1;
                    state_d    = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                // An empty mask spends only the ack cycle here so that ack
                // and done never coincide.
                if (mask_q == '0) begin
                    state_d = ST_DONE;
                end else if (w_tmr_zero) begin
                    if (hold_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_HOLDOFF;
                        w_tmr_load = 1'b1;
                        w_tmr_val  = hold_q - 1'b1;
                    end
                end else begin
                    w_tmr_en = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                if (w_tmr_zero) state_d = ST_DONE;
                else            w_tmr_en = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        // Outputs are registered from the next state, so they line up with
        // the state they describe.
        ack_d  = (state_q == ST_IDLE) && req;
        done_d = (state_d == ST_DONE);
        busy_d = (state_d != ST_IDLE);
        if (done_d && (mask_q != '0) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_d)
            ST_INIT:   dut_rst_d = '1;
            ST_ASSERT: dut_rst_d = mask_d;
            default:   dut_rst_d = '0;
        endcase
        dut_rev_d = (state_d == ST_ASSERT) && rev_d && (mask_d != '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_INIT;
            mask_q    <= '0;
            rev_q     <= 1'b0;
            hold_q    <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            dut_rst_q <= '1;
            dut_rev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            rev_q     <= rev_d;
            hold_q    <= hold_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            dut_rst_q <= dut_rst_d;
            dut_rev_q <= dut_rev_d;
        end
    end

    assign ack               = ack_q;
    assign done              = done_q;
    assign busy              = busy_q;
    assign dut_reset         = dut_rst_q;
    assign dut_reverse_reset = dut_rev_q;
    assign reset_count       = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_dut_reset_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_dut_reset_seq
// Purpose  : Self-checking bench for dut_reset_seq (NUM_DUTS=2). Expected
//            per-cycle output words are queued when a request is driven and
//            compared on each falling edge as the DUT advances.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dut_reset_seq;

    localparam int unsigned c_num_duts = 2;
    localparam int unsigned c_def      = 10;

    logic        clk = 1'b0;
    logic        r_reset;
    logic        r_req;
    logic        r_req_reverse;
    logic [1:0]  r_req_mask;
    logic [7:0]  r_pulse_len;
    logic [7:0]  r_holdoff_len;
    logic        w_ack;
    logic        w_busy;
    logic [1:0]  w_dut_reset;
    logic        w_dut_rev;
    logic        w_done;
    logic [15:0] w_count;

    dut_reset_seq #(
        .NUM_DUTS      (c_num_duts),
        .DEFAULT_PULSE (c_def)
    ) u_dut (
        .clk               (clk),
        .reset             (r_reset),
        .req               (r_req),
        .req_reverse       (r_req_reverse),
        .req_mask          (r_req_mask),
        .pulse_len         (r_pulse_len),
        .holdoff_len       (r_holdoff_len),
        .ack               (w_ack),
        .busy              (w_busy),
        .dut_reset         (w_dut_reset),
        .dut_reverse_reset (w_dut_rev),
        .done              (w_done),
        .reset_count       (w_count)
    );

    always #5 clk = ~clk;

    // Output word layout: {ack, busy, done, reverse, dut_reset[1:0], count}
    typedef logic [21:0] samp_t;
    samp_t w_obs;
    assign w_obs = {w_ack, w_busy, w_done, w_dut_rev, w_dut_reset, w_count};

    samp_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_cnt;

    function automatic samp_t mk(input logic a, input logic b, input logic d,
                                 input logic rv, input logic [1:0] r,
                                 input logic [15:0] c);
        return {a, b, d, rv, r, c};
    endfunction

    // Reference model of one accepted request, starting at the ack cycle and
    // ending with the first IDLE cycle.
    task automatic push_seq(input logic [1:0] mask, input logic rev,
                            input logic [7:0] pl, input logic [7:0] hl);
        int n;
        n = (pl == 8'd0) ? c_def : int'(pl);
        if (mask != 2'b00) begin
            for (int i = 0; i < n; i++)
                exp_q.push_back(mk(i == 0, 1'b1, 1'b0, rev, mask, model_cnt));
            for (int i = 0; i < int'(hl); i++)
                exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, model_cnt));
            if (model_cnt != 16'hFFFF) model_cnt = model_cnt + 16'd1;
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, model_cnt));
        end else begin
            exp_q.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, model_cnt));
            exp_q.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, model_cnt));
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, model_cnt));
    endtask

    task automatic push_init();
        for (int i = 0; i < int'(c_def); i++)
            exp_q.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 2'b11, 16'd0));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 16'd0));
    endtask

    task automatic test_reset();
        samp_t e;
        int    cyc;
        r_reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (w_obs !== mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'd0)) begin
                errors++;
                $display("FAIL reset_hold got %h expected %h", w_obs,
                         mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'd0));
            end
        end
        r_reset   = 1'b0;
        model_cnt = 16'd0;
        push_init();
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL power_on cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
        end
    endtask

    task automatic test_basic();
        samp_t e;
        int    cyc;
        r_req = 1'b1; r_req_mask = 2'b01; r_req_reverse = 1'b0;
        r_pulse_len = 8'd4; r_holdoff_len = 8'd2;
        push_seq(2'b01, 1'b0, 8'd4, 8'd2);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL basic cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            if (w_ack === 1'b1) begin
                // Changing lengths after ack must not disturb this sequence.
                r_req = 1'b0; r_pulse_len = 8'd200; r_holdoff_len = 8'd100;
            end
            cyc++;
        end
        checks++;
        if (w_count !== 16'd1) begin
            errors++;
            $display("FAIL basic_count got %0d expected 1", w_count);
        end
    endtask

    task automatic test_reverse();
        samp_t e;
        int    cyc;
        r_req = 1'b1; r_req_mask = 2'b10; r_req_reverse = 1'b1;
        r_pulse_len = 8'd0; r_holdoff_len = 8'd0;
        push_seq(2'b10, 1'b1, 8'd0, 8'd0);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL reverse cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            if (w_ack === 1'b1) begin
                r_req = 1'b0; r_pulse_len = 8'd3; r_holdoff_len = 8'd5;
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        samp_t e;
        int    cyc;
        int    acks;
        r_req = 1'b1; r_req_mask = 2'b11; r_req_reverse = 1'b0;
        r_pulse_len = 8'd3; r_holdoff_len = 8'd1;
        push_seq(2'b11, 1'b0, 8'd3, 8'd1);
        push_seq(2'b01, 1'b1, 8'd2, 8'd3);
        cyc  = 0;
        acks = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL back_to_back cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            if (w_ack === 1'b1) begin
                acks++;
                if (acks == 1) begin
                    // Second request held high through the first sequence.
                    r_req_mask = 2'b01; r_req_reverse = 1'b1;
                    r_pulse_len = 8'd2; r_holdoff_len = 8'd3;
                end else begin
                    r_req = 1'b0; r_pulse_len = 8'd9; r_holdoff_len = 8'd9;
                end
            end
            cyc++;
        end
    endtask

    task automatic test_mask_zero();
        samp_t e;
        int    cyc;
        r_req = 1'b1; r_req_mask = 2'b00; r_req_reverse = 1'b1;
        r_pulse_len = 8'd5; r_holdoff_len = 8'd4;
        push_seq(2'b00, 1'b1, 8'd5, 8'd4);
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL mask_zero cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            if (w_ack === 1'b1) r_req = 1'b0;
            cyc++;
        end
    endtask

    task automatic test_reset_mid_assert();
        samp_t e;
        int    cyc;
        r_req = 1'b1; r_req_mask = 2'b11; r_req_reverse = 1'b1;
        r_pulse_len = 8'd20; r_holdoff_len = 8'd0;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(mk(i == 0, 1'b1, 1'b0, 1'b1, 2'b11, model_cnt));
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL mid_assert cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            if (w_ack === 1'b1) r_req = 1'b0;
            cyc++;
        end
        r_reset = 1'b1;
        @(negedge clk);
        checks++;
        if (w_obs !== mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'd0)) begin
            errors++;
            $display("FAIL mid_reset_state got %h expected %h", w_obs,
                     mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b11, 16'd0));
        end
        r_reset   = 1'b0;
        model_cnt = 16'd0;
        push_init();
        cyc = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (w_obs !== e) begin
                errors++;
                $display("FAIL mid_reinit cyc %0d got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
        end
    endtask

    initial begin
        r_reset       = 1'b1;
        r_req         = 1'b0;
        r_req_reverse = 1'b0;
        r_req_mask    = 2'b00;
        r_pulse_len   = 8'd0;
        r_holdoff_len = 8'd0;
        model_cnt     = 16'd0;
        test_reset();
        test_basic();
        test_reverse();
        test_back_to_back();
        test_mask_zero();
        test_reset_mid_assert();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
